keypad_code_checker: RTL and testbench

- Consumes decoded keypad presses and produces the mutually exclusive mode levels enab, disab and eegg that select and restart the LED matrix animations downstream.
- Accumulates a 4-digit code. Supports clear and enter keys.
- Compares the entered code against three parameterised codes.
- Handles entry timeout and lockout after repeated failed attempts.

---
 rtl/keypad_code_checker.sv | 152 +++++++++++++++
 tb/tb_keypad_code_checker.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_code_checker.sv
// Keypad code checker: accumulates a 4-digit entry, matches it against three codes and
// drives mutually exclusive mode levels, with entry timeout and lockout after repeated failures.
module keypad_code_checker #(
  parameter logic [15:0] ENABLE_CODE    = 16'h1234,
  parameter logic [15:0] DISABLE_CODE   = 16'h4321,
  parameter logic [15:0] EGG_CODE       = 16'h0155,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCK_CYCLES    = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic       enab,
  output logic       disab,
  output logic       eegg,
  output logic       err,
  output logic       locked,
  output logic [2:0] digits
);

  localparam int TO_W   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int LOCK_W = $clog2(LOCK_CYCLES) + 1;
  localparam int FAIL_W = $clog2(MAX_FAILS) + 1;

  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);

  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  typedef enum logic {ENTRY, LOCKED} state_t;

  state_t            state;
  logic              vld_p0;
  logic [3:0]        key_p0;
  logic [15:0]       entry;
  logic [FAIL_W-1:0] fail_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic [1:0]        restart;
  logic [1:0]        hit_idx;
  logic              hit_active;

  // hit_idx: 0 none, 1 enable, 2 disable, 3 easter egg
  always_comb begin
    hit_idx = 2'd0;
    if (entry == ENABLE_CODE)       hit_idx = 2'd1;
    else if (entry == DISABLE_CODE) hit_idx = 2'd2;
    else if (entry == EGG_CODE)     hit_idx = 2'd3;
    hit_active = (hit_idx == 2'd1 && enab) || (hit_idx == 2'd2 && disab) ||
                 (hit_idx == 2'd3 && eegg);
  end

  // Stage p0 registers the key; the FSM acts on it one edge later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ENTRY;
      vld_p0   <= 1'b0;
      key_p0   <= 4'h0;
      entry    <= 16'h0;
      digits   <= 3'd0;
      fail_cnt <= '0;
      to_cnt   <= '0;
      lock_cnt <= '0;
      restart  <= 2'd0;
      enab     <= 1'b0;
      disab    <= 1'b0;
      eegg     <= 1'b0;
      err      <= 1'b0;
      locked   <= 1'b0;
    end else begin
      vld_p0 <= key_valid;
      key_p0 <= key;
      err    <= 1'b0;

      // Second half of a re-entry: the one-cycle all-low gap is over.
      if (restart != 2'd0) begin
        enab    <= (restart == 2'd1);
        disab   <= (restart == 2'd2);
        eegg    <= (restart == 2'd3);
        restart <= 2'd0;
      end

      case (state)
        ENTRY: begin
          if (fail_cnt == FAIL_MAX) begin
            state    <= LOCKED;
            locked   <= 1'b1;
            lock_cnt <= '0;
            entry    <= 16'h0;
            digits   <= 3'd0;
            to_cnt   <= '0;
          end else if (vld_p0) begin
            to_cnt <= '0;
            if (key_p0 == KEY_CLEAR) begin
              entry  <= 16'h0;
              digits <= 3'd0;
            end else if (key_p0 == KEY_ENTER) begin
              entry  <= 16'h0;
              digits <= 3'd0;
              if (digits == 3'd4 && hit_idx != 2'd0) begin
                fail_cnt <= '0;
                if (hit_active) begin
                  enab    <= 1'b0;
                  disab   <= 1'b0;
                  eegg    <= 1'b0;
                  restart <= hit_idx;
                end else begin
                  enab    <= (hit_idx == 2'd1);
                  disab   <= (hit_idx == 2'd2);
                  eegg    <= (hit_idx == 2'd3);
                  restart <= 2'd0;
                end
              end else begin
                err      <= 1'b1;
                fail_cnt <= fail_cnt + 1'b1;
              end
            end else begin
              entry <= {entry[11:0], key_p0};
              if (digits != 3'd4) digits <= digits + 3'd1;
            end
          end else if (digits == 3'd0) begin
            to_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            entry  <= 16'h0;
            digits <= 3'd0;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (lock_cnt == LOCK_LAST) begin
            state    <= ENTRY;
            locked   <= 1'b0;
            fail_cnt <= '0;
            entry    <= 16'h0;
            digits   <= 3'd0;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_code_checker.sv
// Directed bench for keypad_code_checker with short timeout and lockout parameters.
module tb_keypad_code_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key;
  logic       enab, disab, eegg, err, locked;
  logic [2:0] digits;

  int vectors = 0;
  int miscompares = 0;

  keypad_code_checker #(
    .ENABLE_CODE    (16'h1234),
    .DISABLE_CODE   (16'h4321),
    .EGG_CODE       (16'h0155),
    .TIMEOUT_CYCLES (20),
    .MAX_FAILS      (3),
    .LOCK_CYCLES    (50)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key       (key),
    .enab      (enab),
    .disab     (disab),
    .eegg      (eegg),
    .err       (err),
    .locked    (locked),
    .digits    (digits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One press spans three cycles; it returns just after the FSM has acted on the key.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key = k;
    @(negedge clk);
    key_valid = 1'b0;
    key = 4'h0;
    @(negedge clk);
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    press(4'hF);
  endtask

  initial begin
    reset = 1'b0;
    key_valid = 1'b0;
    key = 4'h0;
    idle(3);
    check("rst_enab", enab, 0);
    check("rst_disab", disab, 0);
    check("rst_eegg", eegg, 0);
    check("rst_err", err, 0);
    check("rst_locked", locked, 0);
    check("rst_digits", digits, 0);
    reset = 1'b1;

    press(4'h1);
    check("digits_1", digits, 1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    check("digits_4", digits, 4);
    press(4'hF);
    check("en_enab", enab, 1);
    check("en_disab", disab, 0);
    check("en_eegg", eegg, 0);
    check("en_digits", digits, 0);
    check("en_err", err, 0);

    enter_code(16'h4321);
    check("dis_enab", enab, 0);
    check("dis_disab", disab, 1);

    enter_code(16'h1234);
    check("en2_enab", enab, 1);
    check("en2_disab", disab, 0);

    enter_code(16'h1234);
    check("gap_enab", enab, 0);
    check("gap_disab", disab, 0);
    check("gap_eegg", eegg, 0);
    idle(1);
    check("regap_enab", enab, 1);

    press(4'h9);
    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    check("sat_digits", digits, 4);
    press(4'hF);
    check("sat_gap_enab", enab, 0);
    check("sat_err", err, 0);
    idle(1);
    check("sat_enab", enab, 1);

    press(4'h1);
    press(4'h2);
    press(4'hF);
    check("short_err", err, 1);
    check("short_enab", enab, 1);
    check("short_digits", digits, 0);
    idle(1);
    check("short_err_pulse", err, 0);

    press(4'h1);
    press(4'h2);
    press(4'hE);
    check("clr_digits", digits, 0);
    check("clr_err", err, 0);
    check("clr_enab", enab, 1);
    enter_code(16'h0155);
    check("egg_eegg", eegg, 1);
    check("egg_enab", enab, 0);
    check("egg_err", err, 0);

    press(4'h1);
    press(4'h2);
    idle(15);
    check("to_before", digits, 2);
    idle(10);
    check("to_after", digits, 0);
    check("to_err", err, 0);
    press(4'h3);
    press(4'h4);
    press(4'hF);
    check("to_short_err", err, 1);
    check("to_eegg", eegg, 1);

    enter_code(16'h1234);
    check("pre_lock_enab", enab, 1);
    check("pre_lock_eegg", eegg, 0);

    enter_code(16'h9999);
    check("wrong1_err", err, 1);
    enter_code(16'h9999);
    check("wrong2_err", err, 1);
    enter_code(16'h9999);
    check("wrong3_err", err, 1);
    check("wrong3_locked", locked, 0);
    idle(1);
    check("lock_locked", locked, 1);
    check("lock_err", err, 0);

    enter_code(16'h4321);
    check("lock_ign_disab", disab, 0);
    check("lock_ign_enab", enab, 1);
    check("lock_ign_err", err, 0);
    check("lock_ign_digits", digits, 0);
    idle(34);
    check("lock_last", locked, 1);
    idle(1);
    check("lock_end", locked, 0);

    enter_code(16'h4321);
    check("post_lock_disab", disab, 1);
    check("post_lock_enab", enab, 0);

    enter_code(16'h9999);
    enter_code(16'h9999);
    enter_code(16'h9999);
    idle(1);
    check("relock_locked", locked, 1);
    reset = 1'b0;
    idle(1);
    check("rst_lock_locked", locked, 0);
    check("rst_lock_disab", disab, 0);
    check("rst_lock_digits", digits, 0);
    reset = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
